top_axi_serdes: RTL and testbench
=================================

TOP_AXI_SERDES -- requirements
Module: top_axi_serdes

Interface
REQ-001 Parameter NUM_PHASES, default 5: width of the multi-phase clock input bus; SHALL be >= 1.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; the clock is tx_clk, the reset is s_axis_reset_n qualified with m_axis_reset_n.
REQ-003 tx_clk  input  1  sole functional clock, rising-edge.
REQ-004 s_axis_reset_n  input  1  synchronous active-low reset.
REQ-005 m_axis_reset_n  input  1  synchronous active-low reset, driven identically to s_axis_reset_n; internal reset = either low.
REQ-006 rx_clk, s_axis_aclk, m_axis_aclk  input  1 each  interface-compatibility ports, same clock net as tx_clk; SHALL NOT be used internally.
REQ-007 clk_phase  input  NUM_PHASES  reserved multi-phase CDR clocks; SHALL NOT clock any logic in this revision; ignored.
REQ-008 s_axis_tdata  input  32  transmit word.
REQ-009 s_axis_valid  input  1  transmit word valid.
REQ-010 s_axis_ready  output  1  block accepts a word this cycle.
REQ-011 m_axis_tdata  output  32  received word.
REQ-012 m_axis_valid  output  1  received word valid.
REQ-013 m_axis_ready  input  1  downstream accepts received word.
REQ-014 VPWR, VGND  inout  1 each  present only when USE_POWER_PINS is defined; no logic.

Function
REQ-015 Block SHALL be a 32-bit AXI-Stream serializer/deserializer in internal loopback: words in on s_axis SHALL exit unchanged and in order on m_axis.
REQ-016 Serial frame, one bit per tx_clk: start bit 1, data bits d0..d31 LSB first, even parity bit (XOR of d[31:0]), stop bit 0; idle line 0.
REQ-017 Serial line SHALL be a register driven by the TX FSM: IDLE, START, DATA (32 cycles, 5-bit counter), PARITY, STOP, then IDLE.
REQ-018 s_axis_ready SHALL be 1 only when TX is IDLE and the single in-flight credit is available; transfer occurs on rising edge with s_axis_valid && s_axis_ready.
REQ-019 Acceptance consumes the credit; credit SHALL return on the edge of the m_axis handshake (m_axis_valid && m_axis_ready) or on a dropped frame.
REQ-020 RX FSM: R_IDLE (wait for line=1), R_DATA (shift 32 bits), R_PARITY, R_STOP.
REQ-021 Latency: word accepted at edge 0 SHALL appear with m_axis_valid=1 after edge 35; with m_axis_ready=1 the handshake completes at edge 36 and s_axis_ready is 1 after edge 36; sustained throughput one word per 37 cycles.
REQ-022 m_axis_tdata/m_axis_valid SHALL hold stable while m_axis_valid && !m_axis_ready.
REQ-023 Parity mismatch or stop bit != 0 SHALL drop the word (m_axis_valid stays 0) and return the credit.
REQ-024 s_axis_valid deassertion while s_axis_ready=1 SHALL cause no transfer; a held s_axis_valid SHALL be re-accepted each time ready returns.

Reset
REQ-025 While reset is low at a rising edge: TX->IDLE, RX->R_IDLE, line=0, credit available, m_axis_valid=0, m_axis_tdata=0, s_axis_ready=0.
REQ-026 s_axis_ready SHALL become 1 on the first edge after reset releases; reset mid-frame SHALL discard the frame with no m_axis output.

Structure
REQ-027 Shared package top_axi_serdes_pkg: DATA_W=32, FRAME_BITS=35, TX and RX state enums.
REQ-028 One sub-module, serdes_rx_deframer (RX FSM, parity check, output register); TX FSM and credit logic in top level.

Verification
REQ-029 Reset low 10 cycles -> s_axis_ready=0, m_axis_valid=0, m_axis_tdata=0; first edge after release -> s_axis_ready=1.
REQ-030 Single word 0xDEADBEEF, m_axis_ready=1 -> m_axis_valid=1 with 0xDEADBEEF exactly 35 cycles after acceptance, for one cycle.
REQ-031 s_axis_valid=1 held with 0xDEADBEEF, m_axis_ready=1, 20000 ns -> word every 37 cycles, all 0xDEADBEEF, none lost or duplicated.
REQ-032 m_axis_ready=0 for 100 cycles after first word -> m_axis_valid and data held, s_axis_ready=0 throughout; release -> next word accepted 1 cycle later.
REQ-033 Sequence 0x00000000, 0xFFFFFFFF, 0x80000001, 0x12345678 -> identical order and values out (parity cases 0/0/0/1).
REQ-034 Reset asserted mid-frame at cycle 15 -> no m_axis_valid for that word; post-reset 0xCAFEF00D delivered normally.

Source files
------------

// File: rtl/top_axi_serdes_pkg.sv
// Shared types and constants for the loopback AXI-Stream serializer/deserializer.
package top_axi_serdes_pkg;

   localparam int DATA_W     = 32;
   localparam int FRAME_BITS = 35;   // start + 32 data + parity + stop
   localparam int CNT_W      = 5;

   // Index of the last data bit within the frame's data field.
   localparam int DATA_LAST  = FRAME_BITS - 4;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_DATA,
      R_PARITY,
      R_STOP
   } rx_state_t;

   // Even parity bit: XOR of all data bits.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/serdes_rx_deframer.sv
// Receive side: samples the serial line, rebuilds the 32-bit word, checks parity
// and stop bit, and presents good words on an AXI-Stream style output register.
module serdes_rx_deframer
   import top_axi_serdes_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              drop
);

   rx_state_t         rx_state;
   rx_state_t         rx_next;
   logic [CNT_W-1:0]  rx_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_ok;
   logic              shift_en;
   logic              par_en;
   logic              done_ok;

   // State register and data-bit counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state <= R_IDLE;
         rx_cnt   <= '0;
      end else begin
         rx_state <= rx_next;
         if (shift_en)
            rx_cnt <= rx_cnt + CNT_W'(1);
         else
            rx_cnt <= '0;
      end
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      rx_next  = rx_state;
      shift_en = 1'b0;
      par_en   = 1'b0;
      done_ok  = 1'b0;
      drop     = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (line)
               rx_next = R_DATA;
         end
         R_DATA: begin
            shift_en = 1'b1;
            if (rx_cnt == CNT_W'(DATA_LAST))
               rx_next = R_PARITY;
         end
         R_PARITY: begin
            par_en  = 1'b1;
            rx_next = R_STOP;
         end
         R_STOP: begin
            rx_next = R_IDLE;
            if (!line && par_ok)
               done_ok = 1'b1;
            else
               drop = 1'b1;
         end
         default: rx_next = R_IDLE;
      endcase
   end

   // LSB-first shift register and parity verdict; pure datapath, no reset.
   always_ff @(posedge clk) begin
      if (shift_en)
         shreg <= {line, shreg[DATA_W-1:1]};
      if (par_en)
         par_ok <= (line == even_parity(shreg));
   end

   // Output register: loads on a good frame, holds until the downstream handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (done_ok) begin
         m_valid <= 1'b1;
         m_data  <= shreg;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/top_axi_serdes.sv
// 32-bit AXI-Stream serializer/deserializer in internal loopback. The TX FSM
// drives a registered serial line; a single credit keeps one word in flight.
module top_axi_serdes
   import top_axi_serdes_pkg::*;
#(
   parameter int NUM_PHASES = 5
)
(
`ifdef USE_POWER_PINS
   inout  wire                   VPWR,
   inout  wire                   VGND,
`endif
   input  logic                  tx_clk,
   input  logic                  rx_clk,
   input  logic                  s_axis_aclk,
   input  logic                  m_axis_aclk,
   input  logic                  s_axis_reset_n,
   input  logic                  m_axis_reset_n,
   input  logic [NUM_PHASES-1:0] clk_phase,
   input  logic [31:0]           s_axis_tdata,
   input  logic                  s_axis_valid,
   output logic                  s_axis_ready,
   output logic [31:0]           m_axis_tdata,
   output logic                  m_axis_valid,
   input  logic                  m_axis_ready
);

   logic              rst_n;
   logic              unused_inputs;
   tx_state_t         tx_state;
   tx_state_t         tx_next;
   logic [CNT_W-1:0]  tx_cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] tx_word;
   logic              line;
   logic              line_next;
   logic              credit;
   logic              credit_next;
   logic              active;
   logic              accept;
   logic              handshake;
   logic              drop;

   // Either reset input pulls the whole block into reset.
   assign rst_n = s_axis_reset_n & m_axis_reset_n;

   // Alias clocks and the reserved CDR phases are deliberately left unconnected.
   assign unused_inputs = ^{rx_clk, s_axis_aclk, m_axis_aclk, clk_phase};

   // Ready needs one clean edge after reset so it reads 0 throughout reset.
   assign s_axis_ready = active && (tx_state == TX_IDLE) && credit;
   assign accept       = s_axis_valid && s_axis_ready;
   assign handshake    = m_axis_valid && m_axis_ready;
   assign cnt_inc      = tx_cnt + CNT_W'(1);

   // TX state, bit counter, serial line, credit and post-reset enable registers.
   always_ff @(posedge tx_clk) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         line     <= 1'b0;
         credit   <= 1'b1;
         active   <= 1'b0;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= cnt_next;
         line     <= line_next;
         credit   <= credit_next;
         active   <= 1'b1;
      end
   end

   // Word capture on acceptance; held for the whole frame.
   always_ff @(posedge tx_clk) begin
      if (accept)
         tx_word <= s_axis_tdata;
   end

   // TX next-state: line_next is the bit the line carries while in tx_next.
   always_comb begin
      tx_next     = tx_state;
      cnt_next    = tx_cnt;
      line_next   = 1'b0;
      credit_next = credit;
      case (tx_state)
         TX_IDLE: begin
            if (accept) begin
               tx_next   = TX_START;
               line_next = 1'b1;
            end
         end
         TX_START: begin
            tx_next   = TX_DATA;
            cnt_next  = '0;
            line_next = tx_word[0];
         end
         TX_DATA: begin
            if (tx_cnt == CNT_W'(DATA_LAST)) begin
               tx_next   = TX_PARITY;
               line_next = even_parity(tx_word);
            end else begin
               cnt_next  = cnt_inc;
               line_next = tx_word[cnt_inc];
            end
         end
         TX_PARITY: begin
            tx_next = TX_STOP;
         end
         TX_STOP: begin
            tx_next = TX_IDLE;
         end
         default: tx_next = TX_IDLE;
      endcase
      if (accept)
         credit_next = 1'b0;
      else if (handshake || drop)
         credit_next = 1'b1;
   end

   serdes_rx_deframer u_rx (
      .clk     (tx_clk),
      .rst_n   (rst_n),
      .line    (line),
      .m_ready (m_axis_ready),
      .m_data  (m_axis_tdata),
      .m_valid (m_axis_valid),
      .drop    (drop)
   );

endmodule

// File: tb/tb_top_axi_serdes.sv
// Bench for top_axi_serdes: table-driven words, throughput, back-pressure and
// mid-frame reset sequences, all checked through an in-order scoreboard.
module tb_top_axi_serdes;

   localparam int LAT = 35;
   localparam int PERIOD = 37;

   logic        tx_clk = 1'b0;
   logic        rx_clk;
   logic        s_axis_aclk;
   logic        m_axis_aclk;
   logic        s_axis_reset_n;
   logic        m_axis_reset_n;
   logic [4:0]  clk_phase;
   logic [31:0] s_axis_tdata;
   logic        s_axis_valid;
   logic        s_axis_ready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_valid;
   logic        m_axis_ready;

   assign rx_clk      = tx_clk;
   assign s_axis_aclk = tx_clk;
   assign m_axis_aclk = tx_clk;

   always #5 tx_clk = ~tx_clk;

   top_axi_serdes #(.NUM_PHASES(5)) dut (
      .tx_clk         (tx_clk),
      .rx_clk         (rx_clk),
      .s_axis_aclk    (s_axis_aclk),
      .m_axis_aclk    (m_axis_aclk),
      .s_axis_reset_n (s_axis_reset_n),
      .m_axis_reset_n (m_axis_reset_n),
      .clk_phase      (clk_phase),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_valid   (s_axis_valid),
      .s_axis_ready   (s_axis_ready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_valid   (m_axis_valid),
      .m_axis_ready   (m_axis_ready)
   );

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          rx_count = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   typedef struct {
      logic [31:0] data;
      logic [31:0] exp_out;
   } vec_t;

   vec_t tbl[6];

   always @(posedge tx_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%h required=none (cycle %0d)", name, act, cyc);
   endtask

   // Scoreboard: latency on each rising valid, data on each handshake.
   always @(negedge tx_clk) begin
      if (s_axis_reset_n && m_axis_reset_n) begin
         if (m_axis_valid && !prev_valid) begin
            if (lat_q.size() == 0)
               fail_event("unexpected_valid", m_axis_tdata);
            else
               check("latency", 32'(cyc - lat_q[0]), 32'(LAT));
         end
         if (m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) begin
               fail_event("extra_word", m_axis_tdata);
            end else begin
               check("rx_data", m_axis_tdata, exp_q.pop_front());
               void'(lat_q.pop_front());
               rx_count++;
            end
         end
      end
      prev_valid = m_axis_valid;
   end

   // Offers a word, waits for acceptance, records expectation and accept edge.
   task automatic send_word(input logic [31:0] data, input logic [31:0] exp,
                            input bit keep, output int acc);
      int n;
      s_axis_tdata = data;
      s_axis_valid = 1'b1;
      n = 0;
      @(negedge tx_clk);
      while (!s_axis_ready && n < 200) begin
         @(negedge tx_clk);
         n++;
      end
      if (!s_axis_ready) begin
         fail_event("accept_timeout", data);
         s_axis_valid = 1'b0;
         acc = -1;
      end else begin
         acc = cyc + 1;
         exp_q.push_back(exp);
         lat_q.push_back(acc);
         @(posedge tx_clk);
         #1;
         if (!keep)
            s_axis_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge tx_clk);
         n++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
      @(posedge tx_clk);
      #1;
   endtask

   task automatic apply_reset(input int n, input string tag);
      s_axis_reset_n = 1'b0;
      m_axis_reset_n = 1'b0;
      s_axis_valid   = 1'b0;
      repeat (n) @(posedge tx_clk);
      #1;
      exp_q.delete();
      lat_q.delete();
      check({tag, "_rst_ready"}, 32'(s_axis_ready), 32'd0);
      check({tag, "_rst_valid"}, 32'(m_axis_valid), 32'd0);
      check({tag, "_rst_tdata"}, m_axis_tdata, 32'd0);
      s_axis_reset_n = 1'b1;
      m_axis_reset_n = 1'b1;
      @(negedge tx_clk);
      check({tag, "_ready_before_edge"}, 32'(s_axis_ready), 32'd0);
      @(posedge tx_clk);
      #1;
      check({tag, "_ready_after_edge"}, 32'(s_axis_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int prev;
      int hs;
      int base;
      int n;

      tbl[0] = '{32'hDEADBEEF, 32'hDEADBEEF};
      tbl[1] = '{32'h00000000, 32'h00000000};
      tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
      tbl[3] = '{32'h80000001, 32'h80000001};
      tbl[4] = '{32'h12345678, 32'h12345678};
      tbl[5] = '{32'h0000_0001, 32'h0000_0001};

      clk_phase    = '0;
      s_axis_tdata = '0;
      s_axis_valid = 1'b0;
      m_axis_ready = 1'b1;

      apply_reset(10, "por");

      // Table of individual words, each drained before the next.
      foreach (tbl[i]) begin
         send_word(tbl[i].data, tbl[i].exp_out, 1'b0, acc);
         wait_drain(100);
      end

      // Held valid: one word every PERIOD cycles, none lost or duplicated.
      base = rx_count;
      prev = -1;
      for (int i = 0; i < 54; i++) begin
         send_word(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, acc);
         if (i > 0)
            check("throughput_spacing", 32'(acc - prev), 32'(PERIOD));
         prev = acc;
      end
      s_axis_valid = 1'b0;
      wait_drain(100);
      check("throughput_count", 32'(rx_count - base), 32'd54);

      // Back-pressure: output held stable and no new acceptance while stalled.
      m_axis_ready = 1'b0;
      send_word(32'hA5A50F0F, 32'hA5A50F0F, 1'b0, acc);
      n = 0;
      while (!m_axis_valid && n < 60) begin
         @(negedge tx_clk);
         n++;
      end
      check("stall_valid_seen", 32'(m_axis_valid), 32'd1);
      s_axis_tdata = 32'h5A5AF0F0;
      s_axis_valid = 1'b1;
      repeat (100) begin
         @(negedge tx_clk);
         check("stall_valid", 32'(m_axis_valid), 32'd1);
         check("stall_data", m_axis_tdata, 32'hA5A50F0F);
         check("stall_ready", 32'(s_axis_ready), 32'd0);
      end
      @(posedge tx_clk);
      #1;
      m_axis_ready = 1'b1;
      hs = cyc + 1;
      send_word(32'h5A5AF0F0, 32'h5A5AF0F0, 1'b0, acc);
      check("release_accept_gap", 32'(acc - hs), 32'd1);
      wait_drain(100);

      // Reset in the middle of a frame discards the word.
      send_word(32'h11112222, 32'h11112222, 1'b0, acc);
      while (cyc < acc + 15)
         @(posedge tx_clk);
      #1;
      apply_reset(3, "mid");
      repeat (50) begin
         @(negedge tx_clk);
         check("mid_no_valid", 32'(m_axis_valid), 32'd0);
      end
      @(posedge tx_clk);
      #1;
      send_word(32'hCAFEF00D, 32'hCAFEF00D, 1'b0, acc);
      wait_drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
